// File: rtl/clock_divider_pkg.sv
// Shared helpers for the multi-channel square-wave generator.
//   ch_w(n)      : width of a channel-select field for n channels (never below 1)
//   presc_w(mhz) : width of the microsecond prescaler counter for a given clock
package clock_divider_pkg;

    function automatic int ch_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    function automatic int presc_w(input int mhz);
        return (mhz <= 1) ? 1 : $clog2(mhz);
    endfunction

endpackage

// File: rtl/multi_clock_divider_if.sv
// Control/status bundle of multi_clock_divider.
//   master : drives EN, SYNC, CFG_WE, CFG_CH, CFG_HALF_US; observes OUT, TICK, US_TICK
//   slave  : the divider side of the same signals
interface multi_clock_divider_if
    import clock_divider_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int HALF_W = 20
);
    logic [NUM_CH-1:0]         EN;
    logic                      SYNC;
    logic                      CFG_WE;
    logic [ch_w(NUM_CH)-1:0]   CFG_CH;
    logic [HALF_W-1:0]         CFG_HALF_US;
    logic [NUM_CH-1:0]         OUT;
    logic [NUM_CH-1:0]         TICK;
    logic                      US_TICK;

    modport master (
        output EN, SYNC, CFG_WE, CFG_CH, CFG_HALF_US,
        input  OUT, TICK, US_TICK
    );

    modport slave (
        input  EN, SYNC, CFG_WE, CFG_CH, CFG_HALF_US,
        output OUT, TICK, US_TICK
    );
endinterface

// File: rtl/divider_channel.sv
// One square-wave channel: half-period counter, active/shadow/pending
// half-period registers, registered output and toggle tick.
//   i_clk, i_rst_n : clock, synchronous active-low reset
//   i_en           : run enable (disabled forces counter and output low)
//   i_sync         : realign: counter and output cleared, pending value applied
//   i_us_stb       : microsecond strobe from the shared prescaler
//   i_we, i_half_us: write of a new half-period into the shadow register
//   o_out, o_tick  : square wave and one-cycle pulse on each toggle
module divider_channel #(
    parameter int HALF_W          = 20,
    parameter int DEFAULT_HALF_US = 500000
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_en,
    input  logic              i_sync,
    input  logic              i_us_stb,
    input  logic              i_we,
    input  logic [HALF_W-1:0] i_half_us,
    output logic              o_out,
    output logic              o_tick
);
    localparam logic [HALF_W-1:0] DEF_HALF = HALF_W'(DEFAULT_HALF_US);

    logic [HALF_W-1:0] r_cnt;
    logic [HALF_W-1:0] r_half;
    logic [HALF_W-1:0] r_shadow;
    logic              r_pend;
    logic              r_out;
    logic              r_tick;

    logic w_stopped;
    logic w_wrap;

    assign w_stopped = (r_half == '0);
    assign w_wrap    = (r_cnt == r_half - 1'b1);

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_cnt    <= '0;
            r_half   <= DEF_HALF;
            r_shadow <= DEF_HALF;
            r_pend   <= 1'b0;
            r_out    <= 1'b0;
            r_tick   <= 1'b0;
        end else begin
            r_tick <= 1'b0;
            if (i_sync || !i_en) begin
                r_cnt <= '0;
                r_out <= 1'b0;
                if (r_pend) begin
                    r_half <= r_shadow;
                    r_pend <= 1'b0;
                end
            end else if (w_stopped) begin
                // Stopped channel holds its level; a new value takes effect at once.
                r_cnt <= '0;
                if (r_pend) begin
                    r_half <= r_shadow;
                    r_pend <= 1'b0;
                end
            end else if (i_us_stb) begin
                if (w_wrap) begin
                    r_cnt  <= '0;
                    r_out  <= ~r_out;
                    r_tick <= 1'b1;
                    // Swapping the period only at the boundary keeps r_cnt below r_half.
                    if (r_pend) begin
                        r_half <= r_shadow;
                        r_pend <= 1'b0;
                    end
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
            // A write landing on an apply edge stays pending for the next boundary.
            if (i_we) begin
                r_shadow <= i_half_us;
                r_pend   <= 1'b1;
            end
        end
    end

    assign o_out  = r_out;
    assign o_tick = r_tick;
endmodule

// File: rtl/multi_clock_divider.sv
// Multi-channel square-wave generator with a shared 1 us prescaler.
//   CLK, RST_N : system clock, synchronous active-low reset
//   bus.EN     : per-channel enable        bus.SYNC : realign all channels
//   bus.CFG_*  : half-period write port    bus.OUT/TICK : per-channel outputs
//   bus.US_TICK: registered 1 us strobe
module multi_clock_divider
    import clock_divider_pkg::*;
#(
    parameter int CLOCK_SPEED_MHZ = 12,
    parameter int NUM_CH          = 4,
    parameter int HALF_W          = 20,
    parameter int DEFAULT_HALF_US = 500000
) (
    input  logic                   CLK,
    input  logic                   RST_N,
    multi_clock_divider_if.slave   bus
);
    localparam int              PW         = presc_w(CLOCK_SPEED_MHZ);
    localparam int              CW         = ch_w(NUM_CH);
    localparam logic [PW-1:0]   PRESC_LAST = PW'(CLOCK_SPEED_MHZ - 1);

    logic [PW-1:0]     r_presc;
    logic              r_us_tick;
    logic              w_us_stb;
    logic [NUM_CH-1:0] w_out;
    logic [NUM_CH-1:0] w_tick;

    // Channels act on the terminal count itself so a toggle lines up with US_TICK.
    assign w_us_stb = (r_presc == PRESC_LAST);

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_presc   <= '0;
            r_us_tick <= 1'b0;
        end else if (bus.SYNC) begin
            r_presc   <= '0;
            r_us_tick <= 1'b0;
        end else begin
            r_us_tick <= w_us_stb;
            r_presc   <= w_us_stb ? '0 : r_presc + 1'b1;
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        logic w_we;
        // Out-of-range CFG_CH values match no channel and are dropped.
        assign w_we = bus.CFG_WE && (bus.CFG_CH == CW'(g));

        divider_channel #(
            .HALF_W          (HALF_W),
            .DEFAULT_HALF_US (DEFAULT_HALF_US)
        ) u_ch (
            .i_clk     (CLK),
            .i_rst_n   (RST_N),
            .i_en      (bus.EN[g]),
            .i_sync    (bus.SYNC),
            .i_us_stb  (w_us_stb),
            .i_we      (w_we),
            .i_half_us (bus.CFG_HALF_US),
            .o_out     (w_out[g]),
            .o_tick    (w_tick[g])
        );
    end

    assign bus.OUT     = w_out;
    assign bus.TICK    = w_tick;
    assign bus.US_TICK = r_us_tick;
endmodule

// File: tb/tb_multi_clock_divider.sv
// Directed bench for multi_clock_divider (4 MHz, 2 channels, 8-bit half, default 3 us).
// Each scenario lists, per edge number after reset, the stimulus and the
// hand-derived edges where US_TICK is high, where each channel toggles, and
// where outputs are forced low without a tick.
module tb_multi_clock_divider;
    localparam int NE = 200;

    logic CLK = 1'b0;
    logic RST_N;
    always #5 CLK = ~CLK;

    multi_clock_divider_if #(.NUM_CH(2), .HALF_W(8)) bus ();

    multi_clock_divider #(
        .CLOCK_SPEED_MHZ (4),
        .NUM_CH          (2),
        .HALF_W          (8),
        .DEFAULT_HALF_US (3)
    ) dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .bus   (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    bit         m_us  [NE];
    bit         m_t0  [NE];
    bit         m_t1  [NE];
    bit         m_clr [NE];
    bit         a_we  [NE];
    logic       a_ch  [NE];
    logic [7:0] a_val [NE];
    bit         a_sync[NE];
    bit         a_rst [NE];
    bit         a_en_set[NE];
    logic [1:0] a_en_val[NE];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %05b expected %05b", tag, got[4:0], exp[4:0]);
        end
    endtask

    task automatic clear_plan();
        for (int i = 0; i < NE; i++) begin
            m_us[i] = 0; m_t0[i] = 0; m_t1[i] = 0; m_clr[i] = 0;
            a_we[i] = 0; a_ch[i] = 1'b0; a_val[i] = 8'd0;
            a_sync[i] = 0; a_rst[i] = 0; a_en_set[i] = 0; a_en_val[i] = 2'b00;
        end
    endtask

    task automatic write_at(input int e, input logic ch, input logic [7:0] val);
        a_we[e] = 1; a_ch[e] = ch; a_val[e] = val;
    endtask

    // Checked vector per edge: {US_TICK, TICK[1:0], OUT[1:0]}.
    task automatic run_scn(input string name, input logic [1:0] en0, input int last_e);
        logic [1:0] exp_out;
        logic [1:0] exp_tick;
        RST_N = 1'b0;
        bus.EN = en0;
        bus.SYNC = 1'b0;
        bus.CFG_WE = 1'b0;
        bus.CFG_CH = 1'b0;
        bus.CFG_HALF_US = 8'd0;
        repeat (2) @(posedge CLK);
        #1;
        exp_out = 2'b00;
        chk({name, " reset"}, {27'd0, bus.US_TICK, bus.TICK, bus.OUT}, 32'd0);
        for (int e = 1; e <= last_e; e++) begin
            RST_N = !a_rst[e];
            bus.SYNC = a_sync[e];
            bus.CFG_WE = a_we[e];
            bus.CFG_CH = a_ch[e];
            bus.CFG_HALF_US = a_val[e];
            if (a_en_set[e]) bus.EN = a_en_val[e];
            @(posedge CLK);
            #1;
            exp_tick = 2'b00;
            if (m_clr[e]) exp_out = 2'b00;
            if (m_t0[e]) begin exp_out[0] = ~exp_out[0]; exp_tick[0] = 1'b1; end
            if (m_t1[e]) begin exp_out[1] = ~exp_out[1]; exp_tick[1] = 1'b1; end
            chk($sformatf("%s e%0d", name, e),
                {27'd0, bus.US_TICK, bus.TICK, bus.OUT},
                {27'd0, m_us[e], exp_tick, exp_out});
        end
        bus.CFG_WE = 1'b0;
        bus.SYNC = 1'b0;
        RST_N = 1'b1;
    endtask

    initial begin
        // Default timing plus running reconfiguration of ch1 to 5 us at edge 14.
        clear_plan();
        for (int k = 4; k <= 44; k += 4) m_us[k] = 1;
        m_t0[12] = 1; m_t0[24] = 1; m_t0[36] = 1;
        m_t1[12] = 1; m_t1[24] = 1; m_t1[44] = 1;
        write_at(14, 1'b1, 8'd5);
        run_scn("cfg_run", 2'b11, 46);

        // SYNC at 30 (both low) and at 44 (both high).
        clear_plan();
        for (int k = 4; k <= 28; k += 4) m_us[k] = 1;
        m_us[34] = 1; m_us[38] = 1; m_us[42] = 1; m_us[48] = 1; m_us[52] = 1;
        m_t0[12] = 1; m_t0[24] = 1; m_t0[42] = 1;
        m_t1[12] = 1; m_t1[24] = 1; m_t1[42] = 1;
        m_clr[30] = 1; m_clr[44] = 1;
        a_sync[30] = 1; a_sync[44] = 1;
        run_scn("sync", 2'b11, 53);

        // Write 1 us to disabled ch0 at edge 2, enable it for the wrap at edge 4.
        clear_plan();
        for (int k = 4; k <= 24; k += 4) begin m_us[k] = 1; m_t0[k] = 1; end
        m_t1[12] = 1; m_t1[24] = 1;
        write_at(2, 1'b0, 8'd1);
        a_en_set[4] = 1; a_en_val[4] = 2'b11;
        run_scn("dis_wr", 2'b10, 25);

        // Half 0 on ch0 takes effect at the rise (edge 12); 2 us written at 112.
        clear_plan();
        for (int k = 4; k <= 128; k += 4) m_us[k] = 1;
        for (int k = 12; k <= 120; k += 12) m_t1[k] = 1;
        m_t0[12] = 1; m_t0[120] = 1; m_t0[128] = 1;
        write_at(6, 1'b0, 8'd0);
        write_at(112, 1'b0, 8'd2);
        run_scn("zero", 2'b11, 130);

        // ch0 at 4 us, then reset at edge 50 restores the 3 us default.
        clear_plan();
        for (int k = 4; k <= 48; k += 4) m_us[k] = 1;
        for (int k = 54; k <= 74; k += 4) m_us[k] = 1;
        m_t0[12] = 1; m_t0[28] = 1; m_t0[44] = 1; m_t0[62] = 1; m_t0[74] = 1;
        m_t1[12] = 1; m_t1[24] = 1; m_t1[36] = 1; m_t1[48] = 1; m_t1[62] = 1; m_t1[74] = 1;
        m_clr[50] = 1;
        write_at(2, 1'b0, 8'd4);
        a_rst[50] = 1;
        run_scn("rst_mid", 2'b11, 76);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
